// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and types for the sort_32_u8 frame controller.
//   ELEM_W / N_ELEM / IDX_W : element width, frame size and index width
//   PAD_VAL_DEFAULT         : fill value for unused slots (sorts to the tail)
//   state_e                 : controller FSM states
package sort_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N_ELEM = 32;
  localparam int unsigned IDX_W  = 5;

  localparam logic [ELEM_W-1:0] PAD_VAL_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    LOAD,
    LAUNCH,
    WAIT,
    DRAIN
  } state_e;

endpackage

// File: rtl/sort_32_u8_ctrl_if.sv
// sort_32_u8_ctrl_if: byte-stream input and sorted-stream output of the controller.
//   s_valid/s_ready/s_data/s_last : input beats (controller is the slave side)
//   m_valid/m_ready/m_data/m_last : sorted output beats
// Modports: slave = controller, master = packet datapath / environment.
interface sort_32_u8_ctrl_if;
  import sort_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [ELEM_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [ELEM_W-1:0] m_data;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/sort_32_u8_ctrl.sv
// sort_32_u8_ctrl: frame sequencer in front of the sort_32_u8 sorter.
// Collects up to 32 bytes, pads the unused slots, launches the sorter with a one-cycle pulse,
// waits for its result (with timeout) and streams back only the valid sorted elements.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   strm (slave)      : s_* input beats, m_* sorted output beats
//   srt_vld_in        : one-cycle launch pulse to the sorter
//   srt_din           : {din_31..din_0}, held stable from LAUNCH until the next LOAD
//   srt_vld_out       : sorter result valid (only observed in WAIT)
//   srt_dout          : {dout_31..dout_0}, ascending
//   busy              : high in every state except LOAD
//   err_timeout       : one-cycle pulse when WAIT gives up
// Optional (macro SORT_CTRL_STAT_EN):
//   frame_cnt         : completed frames, wraps
//   last_lat          : WAIT cycles up to and including the capture cycle of the last result
// TIMEOUT_CYC must lie in 2..255 (8-bit wait timer).
module sort_32_u8_ctrl
  import sort_pkg::*;
#(
  parameter logic [ELEM_W-1:0] PAD_VAL     = PAD_VAL_DEFAULT,
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sort_32_u8_ctrl_if.slave         strm,
  output logic                     srt_vld_in,
  output logic [N_ELEM*ELEM_W-1:0] srt_din,
  input  logic                     srt_vld_out,
  input  logic [N_ELEM*ELEM_W-1:0] srt_dout,
  output logic                     busy,
  output logic                     err_timeout
`ifdef SORT_CTRL_STAT_EN
  ,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               last_lat
`endif
);

  localparam logic [7:0]       TimerLast = 8'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(N_ELEM - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, rd_idx_q;
  logic [IDX_W:0]    n_elem_q;  // 1..32 needs one extra bit
  logic [7:0]        timer_q;
  logic [ELEM_W-1:0] ibuf_q [N_ELEM];
  logic [ELEM_W-1:0] obuf_q [N_ELEM];

  logic s_hs, frame_end, m_hs, m_last_beat, capture;

  assign s_hs        = (state_q == LOAD) && strm.s_valid;
  // s_last or the 32nd beat closes the frame; a following beat opens a new one
  assign frame_end   = s_hs && (strm.s_last || (wr_idx_q == IdxLast));
  assign m_last_beat = ({1'b0, rd_idx_q} == (n_elem_q - (IDX_W+1)'(1)));
  assign m_hs        = (state_q == DRAIN) && strm.m_ready;
  assign capture     = (state_q == WAIT) && srt_vld_out;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/control outputs
  always_comb begin
    state_d      = state_q;
    strm.s_ready = 1'b0;
    strm.m_valid = 1'b0;
    srt_vld_in   = 1'b0;
    err_timeout  = 1'b0;
    unique case (state_q)
      LOAD: begin
        strm.s_ready = 1'b1;
        if (frame_end) state_d = LAUNCH;
      end
      LAUNCH: begin
        srt_vld_in = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        // a result arriving on the timeout cycle still wins
        if (srt_vld_out) begin
          state_d = DRAIN;
        end else if (timer_q == TimerLast) begin
          err_timeout = 1'b1;
          state_d     = LOAD;
        end
      end
      DRAIN: begin
        strm.m_valid = 1'b1;
        if (strm.m_ready && m_last_beat) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Datapath: buffers, indices, wait timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      n_elem_q <= '0;
      timer_q  <= '0;
      for (int k = 0; k < N_ELEM; k++) begin
        ibuf_q[k] <= '0;
        obuf_q[k] <= '0;
      end
    end else begin
      if (s_hs) begin
        ibuf_q[wr_idx_q] <= strm.s_data;
        if (frame_end) begin
          for (int k = 0; k < N_ELEM; k++) begin
            if (IDX_W'(k) > wr_idx_q) ibuf_q[k] <= PAD_VAL;
          end
          n_elem_q <= {1'b0, wr_idx_q} + (IDX_W+1)'(1);
          wr_idx_q <= '0;
        end else begin
          wr_idx_q <= wr_idx_q + IDX_W'(1);
        end
      end

      if (state_q == LAUNCH) timer_q <= '0;
      else if (state_q == WAIT) timer_q <= timer_q + 8'd1;

      if (capture) begin
        for (int k = 0; k < N_ELEM; k++) begin
          obuf_q[k] <= srt_dout[k*ELEM_W +: ELEM_W];
        end
      end

      if (m_hs) rd_idx_q <= m_last_beat ? '0 : rd_idx_q + IDX_W'(1);
    end
  end

  // ibuf only changes in LOAD, so it doubles as the stable sorter input
  always_comb begin
    srt_din = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      srt_din[k*ELEM_W +: ELEM_W] = ibuf_q[k];
    end
  end

  assign strm.m_data = obuf_q[rd_idx_q];
  assign strm.m_last = (state_q == DRAIN) && m_last_beat;
  assign busy        = (state_q != LOAD);

`ifdef SORT_CTRL_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      last_lat  <= '0;
    end else begin
      if (m_hs && m_last_beat) frame_cnt <= frame_cnt + 16'd1;
      // timer_q counts from 0 in the first WAIT cycle
      if (capture) last_lat <= timer_q + 8'd1;
    end
  end
`endif

endmodule
